// File: rtl/nios_practica_pio_ext.sv
// nios_practica_pio_ext: parametrised Avalon-MM GPIO slave (s1).
// Provides WIDTH bits with per-bit direction, atomic set/clear, synchronised
// inputs with sticky edge capture, and a maskable level interrupt.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset
//   address    register select (0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP,
//              4 OUTSET, 5 OUTCLR, 6/7 reserved)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data; bits above WIDTH ignored
//   readdata   registered read data, latency 1; bits above WIDTH read 0
//   in_port    asynchronous input pins
//   out_port   output data register
//   oe         per-bit output enable (direction register)
//   irq        level interrupt, |(edgecap & irqmask)
module nios_practica_pio_ext #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int unsigned      EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam int unsigned ARM_W   = 2;
  localparam logic [ARM_W-1:0] ARM_MAX = 2'd3;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  // Register state
  logic [WIDTH-1:0] data_q, dir_q, mask_q, cap_q;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [ARM_W-1:0] arm_q;
  logic [31:0]      rdata_q;

  // Next-state values
  logic [WIDTH-1:0] data_d, dir_d, mask_d, cap_d;
  logic [ARM_W-1:0] arm_d;
  logic [31:0]      rdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rise, fall, edge_src, capture, clr;
  logic             armed;

  // Upper writedata bits are intentionally ignored when WIDTH < 32
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign wr_en = chipselect & ~write_n;
  assign wd    = writedata[WIDTH-1:0];

  // Edge detection on the synchronised input
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;
  assign armed = (arm_q == ARM_MAX);

  always_comb begin
    edge_src = rise | fall;
    case (EDGE_TYPE)
      0:       edge_src = rise;
      1:       edge_src = fall;
      default: edge_src = rise | fall;
    endcase
  end

  // Register writes and edge-capture update
  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    data_d = wd;
        ADDR_DIR:     dir_d  = wd;
        ADDR_IRQMASK: mask_d = wd;
        ADDR_EDGECAP: clr    = wd;
        ADDR_OUTSET:  data_d = data_q | wd;
        ADDR_OUTCLR:  data_d = data_q & ~wd;
        default:      ;
      endcase
    end
    // A bit that is an output either before or after this edge never captures
    capture = armed ? (edge_src & ~dir_q & ~dir_d) : '0;
    // Set wins over a same-cycle clear so no edge is lost
    cap_d   = (cap_q & ~clr) | capture;
    arm_d   = armed ? arm_q : arm_q + 2'd1;
  end

  // Read mux, registered every clock from the current address
  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA:    rdata_d = 32'((dir_q & data_q) | (~dir_q & s2_q));
      ADDR_DIR:     rdata_d = 32'(dir_q);
      ADDR_IRQMASK: rdata_d = 32'(mask_q);
      ADDR_EDGECAP: rdata_d = 32'(cap_q);
      default:      rdata_d = '0;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE;
      dir_q   <= DIR_RESET;
      mask_q  <= '0;
      cap_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      arm_q   <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      s1_q    <= in_port;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      arm_q   <= arm_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign out_port = data_q;
  assign oe       = dir_q;
  // Derived directly from registers, no extra flop
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_practica_pio_ext.sv
// Bench for nios_practica_pio_ext: three instances (rising, falling, any edge)
// share all inputs; a scoreboard queue holds expected outputs per edge and a
// negedge monitor pops and compares them.
module tb_nios_practica_pio_ext;

  localparam int unsigned W  = 8;
  localparam logic [W-1:0] RV = 8'hA5;
  localparam logic [W-1:0] DR = 8'h0F;
  localparam int NI = 3;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, chipselect, write_n;
  logic [2:0]   address;
  logic [31:0]  writedata;
  logic [W-1:0] in_port;

  logic [31:0]  rd  [NI];
  logic [W-1:0] op  [NI];
  logic [W-1:0] oev [NI];
  logic         irq [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    nios_practica_pio_ext #(
      .WIDTH(W), .RESET_VALUE(RV), .DIR_RESET(DR), .EDGE_TYPE(g)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .readdata(rd[g]), .in_port(in_port), .out_port(op[g]),
      .oe(oev[g]), .irq(irq[g])
    );
  end

  typedef struct {
    int          due;
    int          inst;
    int          kind;   // 0 readdata, 1 out_port, 2 oe, 3 irq
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model state
  logic [W-1:0] m_data, m_dir, m_mask;
  logic [W-1:0] m_cap [NI];
  int           m_rst = 0;
  logic [W-1:0] hist [HMAX];   // pin value present at each edge

  // Pin value as seen by the synchroniser: anything at or before reset is 0
  function automatic logic [W-1:0] eff(input int x);
    if (x < 1 || x <= m_rst) return '0;
    return hist[x];
  endfunction

  function automatic void push(input int due, input int inst, input int kind,
                               input logic [31:0] val);
    exp_t x;
    x.due = due; x.inst = inst; x.kind = kind; x.val = val;
    q.push_back(x);
  endfunction

  // Advance the model across the upcoming edge and queue expectations for it
  task automatic model_edge();
    int           e;
    logic [W-1:0] wd, new_dir, cur, prev, edges, clr;
    logic [31:0]  rv;
    logic         wr, rdc, armed;
    e  = edge_cnt + 1;
    wd = writedata[W-1:0];
    if (e >= HMAX) begin
      $display("FAIL history_overflow edge %0d: got %0d expected below %0d", e, e, HMAX);
      $fatal(1);
    end
    hist[e] = in_port;
    if (!reset_n) begin
      for (int i = 0; i < NI; i++) push(e, i, 0, 32'd0);
      m_data = RV; m_dir = DR; m_mask = '0; m_rst = e;
      for (int i = 0; i < NI; i++) m_cap[i] = '0;
    end else begin
      wr  = chipselect && !write_n;
      rdc = chipselect && write_n;
      if (rdc) begin
        for (int i = 0; i < NI; i++) begin
          case (address)
            3'd0:    rv = 32'((m_dir & m_data) | (~m_dir & eff(e - 2)));
            3'd1:    rv = 32'(m_dir);
            3'd2:    rv = 32'(m_mask);
            3'd3:    rv = 32'(m_cap[i]);
            default: rv = 32'd0;
          endcase
          push(e, i, 0, rv);
        end
      end
      new_dir = (wr && address == 3'd1) ? wd : m_dir;
      clr     = (wr && address == 3'd3) ? wd : '0;
      armed   = (e >= m_rst + 4);
      cur     = eff(e - 2);
      prev    = eff(e - 3);
      for (int i = 0; i < NI; i++) begin
        if (i == 0)      edges = cur & ~prev;
        else if (i == 1) edges = ~cur & prev;
        else             edges = cur ^ prev;
        if (!armed) edges = '0;
        m_cap[i] = (m_cap[i] & ~clr) | (edges & ~m_dir & ~new_dir);
      end
      if (wr) begin
        case (address)
          3'd0: m_data = wd;
          3'd2: m_mask = wd;
          3'd4: m_data = m_data | wd;
          3'd5: m_data = m_data & ~wd;
          default: ;
        endcase
      end
      m_dir = new_dir;
    end
    for (int i = 0; i < NI; i++) begin
      push(e, i, 1, 32'(m_data));
      push(e, i, 2, 32'(m_dir));
      push(e, i, 3, 32'(|(m_cap[i] & m_mask)));
    end
  endtask

  // Monitor: compare everything due at the most recent edge
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= edge_cnt) begin
      exp_t        x;
      logic [31:0] act;
      string       nm;
      x = q.pop_front();
      case (x.kind)
        0:       begin act = rd[x.inst];          nm = "readdata"; end
        1:       begin act = 32'(op[x.inst]);     nm = "out_port"; end
        2:       begin act = 32'(oev[x.inst]);    nm = "oe";       end
        default: begin act = 32'(irq[x.inst]);    nm = "irq";      end
      endcase
      n_checks++;
      if (act !== x.val || x.due != edge_cnt) begin
        n_errors++;
        $display("FAIL %s inst%0d edge %0d: got %h expected %h", nm, x.inst,
                 x.due, act, x.val);
      end
    end
  end

  logic [W-1:0] pins = '0;

  task automatic step(input logic rn, input logic cs, input logic wn,
                      input logic [2:0] a, input logic [31:0] d);
    reset_n    = rn;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    in_port    = pins;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rdr(input logic [2:0] a);
    step(1'b1, 1'b1, 1'b1, a, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0; in_port = '0;

    // Reset, including a write presented while reset is low
    step(1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 32'hFF);
    step(1'b0, 1'b1, 1'b0, 3'd1, 32'hFF);
    for (int a = 0; a < 8; a++) rdr(3'(a));

    // Reset pulsed in the middle of writes
    wr(3'd2, 32'hFF);
    step(1'b0, 1'b1, 1'b0, 3'd0, 32'h3C);
    for (int a = 0; a < 4; a++) rdr(3'(a));

    // Output path: DATA, OUTSET, OUTCLR
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'h0F);
    wr(3'd4, 32'h30);
    wr(3'd5, 32'h03);
    rdr(3'd0);
    rdr(3'd0);

    // Rising edge on bit 2, masked then unmasked
    wr(3'd1, 32'h00);
    wr(3'd2, 32'h00);
    idle(4);
    pins = 8'h04;
    idle(4);
    rdr(3'd3);
    wr(3'd2, 32'h04);
    idle(1);
    rdr(3'd3);

    // Clear coinciding with a new rise on bit 2, then a plain clear
    pins = 8'h00;
    idle(4);
    wr(3'd3, 32'hFF);
    pins = 8'h04;
    idle(2);
    wr(3'd3, 32'h04);
    rdr(3'd3);
    idle(3);
    wr(3'd3, 32'hFF);
    rdr(3'd3);
    idle(2);

    // Pins high through reset produce no edge; then a falling edge on bit 0
    pins = 8'hFF;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
    wr(3'd1, 32'h00);
    wr(3'd2, 32'hFF);
    idle(6);
    rdr(3'd3);
    pins = 8'hFE;
    idle(4);
    rdr(3'd3);
    rdr(3'd0);

    // Output-direction bit ignores pin toggles
    wr(3'd3, 32'hFF);
    wr(3'd1, 32'h20);
    wr(3'd0, 32'h00);
    for (int i = 0; i < 6; i++) begin
      pins = pins ^ 8'h20;
      idle(2);
    end
    rdr(3'd0);
    rdr(3'd3);
    rdr(3'd6);
    rdr(3'd7);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      logic        rn, cs, wn;
      logic [2:0]  a;
      logic [31:0] d;
      if ($urandom_range(3) == 0) pins = pins ^ W'($urandom);
      rn = ($urandom_range(79) != 0);
      cs = ($urandom_range(3) != 0);
      wn = ($urandom_range(1) == 1);
      a  = 3'($urandom_range(7));
      d  = $urandom;
      step(rn, cs, wn, a, d);
    end

    idle(2);
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
